spi_dac_tx: RTL and testbench

Serialising transmitter that carries 10-bit offset-binary audio samples from the processor output to the external SPI DAC (MCP4911-class, 16-bit write frame). It accepts one sample per load strobe, keeps a one-deep pending buffer for back-to-back loads, and drives chip-select, serial clock, serial data and the latch strobe. It is the output-side counterpart of the ADC sampling path feeding the processor.

---
 rtl/dac_pkg.sv | 37 +++
 rtl/sck_tick_gen.sv | 25 ++
 rtl/spi_dac_tx.sv | 143 ++++++++++++++
 tb/tb_spi_dac_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants, state encoding and frame builder for the MCP4911-class SPI DAC transmitter.
package dac_pkg;

  localparam int FRAME_W  = 16;
  localparam int SAMPLE_W = 10;

  localparam int CH_POS   = 15;
  localparam int BUF_POS  = 14;
  localparam int GA_POS   = 13;
  localparam int SHDN_POS = 12;

  localparam int DEFAULT_CLK_DIV = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Channel A, active output, sample left-justified below the control nibble.
  function automatic logic [FRAME_W-1:0] make_frame(
    input logic [SAMPLE_W-1:0] sample,
    input logic                buf_en,
    input logic                ga_n
  );
    logic [FRAME_W-1:0] w;
    w                         = '0;
    w[CH_POS]                 = 1'b0;
    w[BUF_POS]                = buf_en;
    w[GA_POS]                 = ga_n;
    w[SHDN_POS]               = 1'b1;
    w[SHDN_POS-1 -: SAMPLE_W] = sample;
    return w;
  endfunction

endpackage

// File: rtl/sck_tick_gen.sv
// Half-period counter: one-cycle tick every CLK_DIV cycles, restarted by a sync clear.
module sck_tick_gen
  import dac_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr || tick) cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_dac_tx.sv
// SPI DAC write-frame serialiser with a one-deep pending sample and LDAC latch strobe.
// Every pin is a flop fed from the current FSM state, so pins trail the state by one cycle.
module spi_dac_tx
  import dac_pkg::*;
#(
  parameter int   CLK_DIV  = DEFAULT_CLK_DIV,
  parameter logic BUF_BIT  = 1'b0,
  parameter logic GA_N_BIT = 1'b1
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] data_in,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic                dac_cs_n,
  output logic                dac_sck,
  output logic                dac_sdi,
  output logic                dac_ldac_n
);

  localparam int BIT_W = $clog2(FRAME_W);

  state_t             state, state_nxt;
  logic               tick, tick_clr;
  logic               sck_hi;
  logic [BIT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] pend_word;
  logic               pend_vld;
  logic [FRAME_W-1:0] load_word;

  logic lat_exit, start_new, start_pend, capture, fall_edge;
  logic cs_n_c, sck_c, sdi_c, ldac_n_c, busy_c, done_c, overrun_c;

  assign load_word = make_frame(data_in, BUF_BIT, GA_N_BIT);

  sck_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (sysclk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  assign tick_clr   = (state_nxt != state);
  assign fall_edge  = (state == SHIFT) && tick && sck_hi;
  assign lat_exit   = (state == LATCH) && tick;
  // A load at LATCH exit with nothing pending goes straight out rather than via pending.
  assign start_new  = load && ((state == IDLE) || (lat_exit && !pend_vld));
  assign start_pend = lat_exit && pend_vld;
  assign capture    = load && (state != IDLE) && !start_new;

  always_ff @(posedge sysclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (fall_edge && (bit_cnt == '0)) state_nxt = GAP;
      GAP:     if (tick) state_nxt = LATCH;
      LATCH:   if (tick) state_nxt = (pend_vld || load) ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cs_n_c   = 1'b1;
    sck_c    = 1'b0;
    sdi_c    = 1'b0;
    ldac_n_c = 1'b1;
    busy_c   = (state != IDLE);
    unique case (state)
      SHIFT: begin
        cs_n_c = 1'b0;
        sck_c  = sck_hi;
        sdi_c  = shreg[FRAME_W-1];
      end
      LATCH:   ldac_n_c = 1'b0;
      default: ;
    endcase
  end

  assign done_c    = lat_exit;
  assign overrun_c = capture && pend_vld;

  // SDI only moves on the falling boundary, so it is stable across every rising SCK.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sck_hi  <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if ((state != SHIFT) || (state_nxt != SHIFT)) sck_hi <= 1'b0;
      else if (tick)                                sck_hi <= ~sck_hi;

      if (start_new || start_pend) bit_cnt <= BIT_W'(FRAME_W - 1);
      else if (fall_edge)          bit_cnt <= bit_cnt - BIT_W'(1);

      if (start_new)       shreg <= load_word;
      else if (start_pend) shreg <= pend_word;
      else if (fall_edge)  shreg <= {shreg[FRAME_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      pend_vld  <= 1'b0;
      pend_word <= '0;
    end else begin
      if (capture) begin
        pend_vld  <= 1'b1;
        pend_word <= load_word;
      end else if (start_pend) begin
        pend_vld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      dac_cs_n   <= 1'b1;
      dac_sck    <= 1'b0;
      dac_sdi    <= 1'b0;
      dac_ldac_n <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dac_cs_n   <= cs_n_c;
      dac_sck    <= sck_c;
      dac_sdi    <= sdi_c;
      dac_ldac_n <= ldac_n_c;
      busy       <= busy_c;
      done       <= done_c;
      overrun    <= overrun_c;
    end
  end

endmodule

// File: tb/tb_spi_dac_tx.sv
// Bench for spi_dac_tx: pin-level frame decoder plus a timeline model of frame slots and pending.
module tb_spi_dac_tx;

  localparam int N         = 2;
  localparam int FRAME_CYC = 34 * N;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic       reset, load;
  logic [9:0] data_in;
  logic       busy, done, overrun, dac_cs_n, dac_sck, dac_sdi, dac_ldac_n;

  logic       reset4, load4;
  logic [9:0] data4;
  logic       busy4, done4, ovr4, cs4, sck4, sdi4, ldac4;

  spi_dac_tx #(.CLK_DIV(N)) dut (
    .sysclk(sysclk), .reset(reset), .data_in(data_in), .load(load),
    .busy(busy), .done(done), .overrun(overrun), .dac_cs_n(dac_cs_n),
    .dac_sck(dac_sck), .dac_sdi(dac_sdi), .dac_ldac_n(dac_ldac_n)
  );

  spi_dac_tx #(.CLK_DIV(4)) dut4 (
    .sysclk(sysclk), .reset(reset4), .data_in(data4), .load(load4),
    .busy(busy4), .done(done4), .overrun(ovr4), .dac_cs_n(cs4),
    .dac_sck(sck4), .dac_sdi(sdi4), .dac_ldac_n(ldac4)
  );

  typedef struct {
    logic [9:0]  d;
    logic [15:0] frame;
  } vec_t;
  vec_t tbl[5];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Timeline model: each started frame owns FRAME_CYC edges; exit edge may start the next.
  logic        m_active = 1'b0, m_pend = 1'b0, m_busy = 1'b0, m_busy_prev = 1'b0;
  int          m_end = 0, m_done_exp = 0, m_ovr_exp = 0;
  logic [15:0] m_pend_word;
  logic [15:0] exp_q[$];

  logic        cs_q = 1'b1, sck_q = 1'b0;
  logic [15:0] rx_sh = '0;
  int          rx_bits = 0;
  logic [15:0] rx_q[$];
  int cs_low, ldac_low, done_cnt = 0, ovr_cnt = 0, done_cyc, ovr_cyc, first_rise;

  function automatic logic [15:0] exp_frame(input logic [9:0] d);
    return 16'h3000 + 16'(d) * 16'd4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_start(input logic [15:0] w);
    m_active = 1'b1;
    m_end    = cyc + FRAME_CYC;
    exp_q.push_back(w);
  endtask

  task automatic model_edge(input logic rst, input logic ld, input logic [9:0] d);
    cyc++;
    m_busy_prev = m_busy;
    if (rst) begin
      if (m_active) exp_q.delete(exp_q.size() - 1);
      m_active = 1'b0; m_pend = 1'b0; m_busy = 1'b0; m_busy_prev = 1'b0;
    end else begin
      if (m_active && cyc == m_end) begin
        m_done_exp++;
        if (m_pend) begin
          m_start(m_pend_word);
          m_pend = 1'b0;
          if (ld) begin m_pend = 1'b1; m_pend_word = exp_frame(d); m_ovr_exp++; end
        end else if (ld) m_start(exp_frame(d));
        else m_active = 1'b0;
      end else if (!m_active) begin
        if (ld) m_start(exp_frame(d));
      end else if (ld) begin
        if (m_pend) m_ovr_exp++;
        m_pend = 1'b1; m_pend_word = exp_frame(d);
      end
      m_busy = m_active;
    end
  endtask

  task automatic observe();
    if (!dac_cs_n)   cs_low++;
    if (!dac_ldac_n) ldac_low++;
    if (done)    begin done_cnt++; done_cyc = cyc; end
    if (overrun) begin ovr_cnt++;  ovr_cyc  = cyc; end
    if (dac_sck && !sck_q && first_rise < 0) first_rise = cyc;
    if (!dac_cs_n && dac_sck && !sck_q) begin
      rx_sh = {rx_sh[14:0], dac_sdi};
      rx_bits++;
    end
    if (dac_cs_n && !cs_q) begin
      if (rx_bits == 16) rx_q.push_back(rx_sh);
      rx_bits = 0;
    end
    cs_q  = dac_cs_n;
    sck_q = dac_sck;
    check("busy", 32'(busy), 32'(m_busy_prev));
  endtask

  task automatic step(input logic rst, input logic ld, input logic [9:0] d);
    reset = rst; load = ld; data_in = d;
    model_edge(rst, ld, d);
    @(posedge sysclk);
    @(negedge sysclk);
    observe();
  endtask

  task automatic clr_stats();
    cs_low = 0; ldac_low = 0; done_cyc = -1; ovr_cyc = -1; first_rise = -1;
  endtask

  task automatic check_frames(input string name);
    check({name, "_frame_count"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check({name, "_frame"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int k;
    reset = 1'b1; load = 1'b0; data_in = '0;
    reset4 = 1'b1; load4 = 1'b0; data4 = '0;
    tbl[0] = '{10'h200, 16'h3800};
    tbl[1] = '{10'h3FF, 16'h3FFC};
    tbl[2] = '{10'h000, 16'h3000};
    tbl[3] = '{10'h155, 16'h3554};
    tbl[4] = '{10'h0AA, 16'h32A8};
    clr_stats();
    @(negedge sysclk);

    // Reset held, then idle with no load: pins stay at rest.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, '0);
      check("idle_outputs", {25'b0, dac_cs_n, dac_sck, dac_sdi, dac_ldac_n, busy, done, overrun},
            32'b1001000);
    end

    // Single frames from the vector table.
    for (int t = 0; t < 5; t++) begin
      clr_stats();
      step(1'b0, 1'b1, tbl[t].d);
      k = cyc;
      repeat (80) step(1'b0, 1'b0, '0);
      check("tbl_rx_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check("tbl_frame", 32'(rx_q[0]), 32'(tbl[t].frame));
      check("tbl_cs_low", cs_low, 32 * N);
      check("tbl_ldac_low", ldac_low, N);
      check("tbl_done_at", done_cyc - k, FRAME_CYC);
      check("tbl_first_sck_rise", first_rise - k, N + 1);
      check_frames("tbl");
    end

    // Pending and overrun: second load is overwritten by the third.
    clr_stats();
    k = ovr_cnt;
    step(1'b0, 1'b1, 10'h155);
    repeat (9) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 10'h0AA);
    repeat (9) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 10'h123);
    begin
      int t20;
      t20 = cyc;
      repeat (200) step(1'b0, 1'b0, '0);
      check("pend_overrun_count", ovr_cnt - k, 1);
      check("pend_overrun_at", ovr_cyc, t20);
    end
    check("pend_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("pend_frame0", 32'(rx_q[0]), 32'h3554);
      check("pend_frame1", 32'(rx_q[1]), 32'h348C);
    end
    check_frames("pend");

    // Load on the LATCH exit edge starts at once; a mid-frame load waits for the slot.
    clr_stats();
    step(1'b0, 1'b1, 10'h0F0);
    k = cyc;
    repeat (FRAME_CYC - 1) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 10'h00F);
    check("exit_done_first", done_cyc - k, FRAME_CYC);
    repeat (39) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 10'h3C3);
    repeat (200) step(1'b0, 1'b0, '0);
    check("exit_done_last", done_cyc - k, 3 * FRAME_CYC);
    check_frames("exit");

    // Random load traffic against the timeline model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) step(1'b0, 1'b1, 10'($urandom));
      else                            step(1'b0, 1'b0, '0);
    end
    repeat (200) step(1'b0, 1'b0, '0);
    check_frames("rand");
    check("rand_done_total", done_cnt, m_done_exp);
    check("rand_overrun_total", ovr_cnt, m_ovr_exp);

    // Mid-frame reset on the CLK_DIV=4 instance with a sample pending.
    begin
      int rises, dn, bz;
      logic s4q;
      reset4 = 1'b0;
      step(1'b0, 1'b0, '0);
      load4 = 1'b1; data4 = 10'h2A5;
      step(1'b0, 1'b0, '0);
      load4 = 1'b0;
      repeat (10) step(1'b0, 1'b0, '0);
      load4 = 1'b1; data4 = 10'h05A;
      step(1'b0, 1'b0, '0);
      load4 = 1'b0;
      rises = 0; s4q = sck4;
      for (int i = 0; i < 500 && rises < 7; i++) begin
        step(1'b0, 1'b0, '0);
        if (sck4 && !s4q) rises++;
        s4q = sck4;
      end
      check("r4_seven_rises", rises, 7);
      reset4 = 1'b1;
      step(1'b0, 1'b0, '0);
      reset4 = 1'b0;
      check("r4_cs_n_after_reset", 32'(cs4), 1);
      check("r4_sck_after_reset", 32'(sck4), 0);
      dn = 0; bz = 0;
      for (int i = 0; i < 300; i++) begin
        step(1'b0, 1'b0, '0);
        if (done4) dn++;
        if (busy4) bz++;
      end
      check("r4_no_done", dn, 0);
      check("r4_pending_cleared", bz, 0);
    end

    // Ramp pass-through, one sample per 69 cycles: no overruns, stream equals ramp.
    k = ovr_cnt;
    for (int i = 0; i < 1024; i++) begin
      step(1'b0, 1'b1, 10'(i));
      repeat (FRAME_CYC) step(1'b0, 1'b0, '0);
    end
    repeat (100) step(1'b0, 1'b0, '0);
    check("ramp_overruns", ovr_cnt - k, 0);
    check("ramp_count", rx_q.size(), 1024);
    for (int i = 0; i < rx_q.size(); i++) begin
      logic [15:0] w;
      w = rx_q[i];
      check("ramp_sample", 32'(w[11:2]), 32'(i));
    end
    check_frames("ramp");
    check("final_done_total", done_cnt, m_done_exp);
    check("final_overrun_total", ovr_cnt, m_ovr_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
